// File: rtl/cdma_rd_cmd_gen_if.sv
// Bundle of job-request and read-command signals for cdma_rd_cmd_gen.
// The "slave" modport is the command generator's view of the bundle.
// The "master" modport is the view of the job source and the read engine.
interface cdma_rd_cmd_gen_if #(
    parameter int ADDR_BITS = 64,
    parameter int LEN_BITS  = 32
) ();

    // Job request side
    logic                 job_valid;
    logic                 job_ready;
    logic [ADDR_BITS-1:0] job_addr;
    logic [LEN_BITS-1:0]  job_len;
    logic [LEN_BITS-1:0]  job_chunk;
    logic                 job_done;
    logic                 busy;
    logic                 err_spurious;

    // Read command side toward the CDMA read engine
    logic                 rd_valid;
    logic                 rd_ready;
    logic [ADDR_BITS-1:0] rd_paddr;
    logic [LEN_BITS-1:0]  rd_len;
    logic                 rd_done;

    modport slave (
        input  job_valid,
        input  job_addr,
        input  job_len,
        input  job_chunk,
        input  rd_ready,
        input  rd_done,
        output job_ready,
        output job_done,
        output busy,
        output err_spurious,
        output rd_valid,
        output rd_paddr,
        output rd_len
    );

    modport master (
        output job_valid,
        output job_addr,
        output job_len,
        output job_chunk,
        output rd_ready,
        output rd_done,
        input  job_ready,
        input  job_done,
        input  busy,
        input  err_spurious,
        input  rd_valid,
        input  rd_paddr,
        input  rd_len
    );

endinterface

// File: rtl/cdma_rd_cmd_gen.sv
// CDMA read command generator.
// Splits one job (base address, total length, chunk size) into a stream of
// read commands of at most one chunk each, keeps at most MAX_OUTSTANDING
// commands in flight, and pulses job_done once every command has completed.
// The interface instance must be built with the same ADDR_BITS/LEN_BITS.
module cdma_rd_cmd_gen #(
    parameter int ADDR_BITS       = 64,
    parameter int LEN_BITS        = 32,
    parameter int MAX_OUTSTANDING = 8
) (
    input  logic              aclk,
    input  logic              areset,
    cdma_rd_cmd_gen_if.slave  bus
);

    localparam int                OW      = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [OW-1:0]     MAX_CNT = OW'(MAX_OUTSTANDING);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t               state_q;
    logic                 rd_valid_q;
    logic [ADDR_BITS-1:0] rd_paddr_q;
    logic [LEN_BITS-1:0]  rd_len_q;
    logic                 job_done_q;
    logic                 err_q;
    logic [OW-1:0]        outstanding_q;
    logic [OW-1:0]        outstanding_d;
    logic [LEN_BITS-1:0]  remaining_q;
    logic [ADDR_BITS-1:0] cur_addr_q;
    logic [LEN_BITS-1:0]  chunk_q;

    logic                 accept;
    logic                 hs;
    logic                 spurious;
    logic [ADDR_BITS-1:0] addr_d;
    logic [LEN_BITS-1:0]  rem_d;
    logic [LEN_BITS-1:0]  next_len;
    logic                 can_load;

    // Job acceptance only in IDLE; the command handshake only exists while rd_valid is up.
    assign accept = bus.job_valid && (state_q == IDLE);
    assign hs     = rd_valid_q && bus.rd_ready;

    // In-flight command count: a handshake adds one, a completion removes one,
    // both together cancel. A completion with nothing in flight is flagged.
    always_comb begin
        outstanding_d = outstanding_q;
        spurious      = 1'b0;
        unique case ({hs, bus.rd_done})
            2'b10:   outstanding_d = outstanding_q + 1'b1;
            2'b01: begin
                if (outstanding_q != '0) begin
                    outstanding_d = outstanding_q - 1'b1;
                end else begin
                    spurious = 1'b1;
                end
            end
            default: outstanding_d = outstanding_q;
        endcase
    end

    // Address/remaining as they stand after this cycle's handshake (if any),
    // and whether the next command can be loaded back-to-back.
    always_comb begin
        addr_d   = cur_addr_q;
        rem_d    = remaining_q;
        if (hs) begin
            addr_d = cur_addr_q + ADDR_BITS'(rd_len_q);
            rem_d  = remaining_q - rd_len_q;
        end
        next_len = (rem_d < chunk_q) ? rem_d : chunk_q;
        can_load = (state_q == ISSUE) && (!rd_valid_q || hs) &&
                   (rem_d != '0) && (outstanding_d < MAX_CNT);
    end

    // Control FSM with registered command/status outputs.
    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q       <= IDLE;
            rd_valid_q    <= 1'b0;
            rd_paddr_q    <= '0;
            rd_len_q      <= '0;
            job_done_q    <= 1'b0;
            err_q         <= 1'b0;
            outstanding_q <= '0;
            remaining_q   <= '0;
        end else begin
            outstanding_q <= outstanding_d;
            job_done_q    <= 1'b0;
            if (spurious) begin
                err_q <= 1'b1;
            end
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        remaining_q <= bus.job_len;
                        if (bus.job_len == '0) begin
                            state_q    <= DONE;
                            job_done_q <= 1'b1;
                        end else begin
                            state_q <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    remaining_q <= rem_d;
                    if (can_load) begin
                        rd_valid_q <= 1'b1;
                        rd_paddr_q <= addr_d;
                        rd_len_q   <= next_len;
                    end else if (hs) begin
                        rd_valid_q <= 1'b0;
                    end
                    if (hs && (rem_d == '0)) begin
                        state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (outstanding_d == '0) begin
                        state_q    <= DONE;
                        job_done_q <= 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Job datapath: base address and chunk size captured at acceptance, address
    // advanced by each accepted command (wrapping naturally at ADDR_BITS).
    always_ff @(posedge aclk) begin
        if (accept) begin
            cur_addr_q <= bus.job_addr;
            chunk_q    <= (bus.job_chunk == '0) ? bus.job_len : bus.job_chunk;
        end else begin
            cur_addr_q <= addr_d;
        end
    end

    assign bus.job_ready    = (state_q == IDLE);
    assign bus.busy         = (state_q != IDLE);
    assign bus.job_done     = job_done_q;
    assign bus.err_spurious = err_q;
    assign bus.rd_valid     = rd_valid_q;
    assign bus.rd_paddr     = rd_paddr_q;
    assign bus.rd_len       = rd_len_q;

endmodule

// File: tb/tb_cdma_rd_cmd_gen.sv
// Directed bench for cdma_rd_cmd_gen with a command scoreboard.
module tb_cdma_rd_cmd_gen;

    localparam int DONE_DLY = 5;

    typedef struct {
        logic [63:0] a;
        logic [31:0] l;
    } cmd_t;

    logic aclk;
    logic areset;

    cdma_rd_cmd_gen_if #(.ADDR_BITS(64), .LEN_BITS(32)) bus ();

    cdma_rd_cmd_gen #(
        .ADDR_BITS      (64),
        .LEN_BITS       (32),
        .MAX_OUTSTANDING(2)
    ) dut (
        .aclk  (aclk),
        .areset(areset),
        .bus   (bus)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    int   ntests = 0;
    int   nfail  = 0;
    int   cyc    = 0;
    int   nhs    = 0;
    int   njd    = 0;
    int   last_done_cyc = 0;
    int   jd_cyc = 0;
    bit   auto_done = 1'b0;
    cmd_t exp_q[$];
    int   timers[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock: observe outputs on the falling edge, drive rd_done after the rising edge.
    task automatic tick();
        bit   fire;
        cmd_t e;
        @(negedge aclk);
        cyc++;
        if (cyc > 20000) begin
            $display("FAIL watchdog: observed %0d cycles expected under 20000", cyc);
            $fatal(1, "cycle budget exhausted");
        end
        if (bus.rd_done) last_done_cyc = cyc;
        if (bus.job_done) begin
            njd++;
            jd_cyc = cyc;
        end
        if (bus.rd_valid && bus.rd_ready) begin
            nhs++;
            if (exp_q.size() == 0) begin
                ntests++;
                nfail++;
                $error("FAIL cmd_unexpected: observed addr 0x%0h len 0x%0h expected no command",
                       bus.rd_paddr, bus.rd_len);
            end else begin
                e = exp_q.pop_front();
                chk("cmd_addr", bus.rd_paddr, e.a);
                chk("cmd_len", 64'(bus.rd_len), 64'(e.l));
            end
            if (auto_done) timers.push_back(DONE_DLY);
        end
        @(posedge aclk);
        #1;
        fire = 1'b0;
        for (int i = 0; i < timers.size(); i++) timers[i] = timers[i] - 1;
        if (timers.size() > 0 && timers[0] == 0) begin
            fire = 1'b1;
            void'(timers.pop_front());
        end
        bus.rd_done = fire;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Drive one job for a single cycle and push the commands it should produce.
    task automatic start_job(input logic [63:0] addr, input logic [31:0] len, input logic [31:0] chunk);
        logic [63:0] a;
        logic [31:0] r;
        logic [31:0] c;
        cmd_t        e;
        a = addr;
        r = len;
        c = (chunk == 0) ? len : chunk;
        while (r != 0) begin
            e.a = a;
            e.l = (r < c) ? r : c;
            exp_q.push_back(e);
            a = a + 64'(e.l);
            r = r - e.l;
        end
        chk("job_ready_before_accept", 64'(bus.job_ready), 64'd1);
        bus.job_valid = 1'b1;
        bus.job_addr  = addr;
        bus.job_len   = len;
        bus.job_chunk = chunk;
        tick();
        bus.job_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = njd;
        for (int i = 0; i < 400 && njd == n; i++) tick();
        chk(tag, 64'(njd - n), 64'd1);
    endtask

    int h0;
    int j0;

    initial begin
        areset        = 1'b1;
        bus.job_valid = 1'b0;
        bus.job_addr  = '0;
        bus.job_len   = '0;
        bus.job_chunk = '0;
        bus.rd_ready  = 1'b0;
        bus.rd_done   = 1'b0;
        ticks(2);

        // Reset values
        chk("rst_rd_valid", 64'(bus.rd_valid), 64'd0);
        chk("rst_job_done", 64'(bus.job_done), 64'd0);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_err", 64'(bus.err_spurious), 64'd0);
        chk("rst_paddr", bus.rd_paddr, 64'd0);
        chk("rst_len", 64'(bus.rd_len), 64'd0);
        areset = 1'b0;
        chk("ready_after_rst", 64'(bus.job_ready), 64'd1);

        // Basic 4-command job, completions 5 cycles after each handshake
        auto_done    = 1'b1;
        bus.rd_ready = 1'b1;
        h0 = nhs;
        start_job(64'h1000, 32'h1000, 32'h400);
        chk("busy_after_accept", 64'(bus.busy), 64'd1);
        chk("not_ready_when_busy", 64'(bus.job_ready), 64'd0);
        bus.job_valid = 1'b1;
        bus.job_addr  = 64'hDEAD_0000;
        bus.job_len   = 32'h40;
        bus.job_chunk = 32'h40;
        ticks(3);
        bus.job_valid = 1'b0;
        wait_done("job1_done");
        chk("job1_done_after_last_rd_done", 64'(jd_cyc - last_done_cyc), 64'd1);
        j0 = njd;
        ticks(3);
        chk("job1_done_single_pulse", 64'(njd - j0), 64'd0);
        chk("job1_cmds", 64'(nhs - h0), 64'd4);
        chk("job1_sb_empty", 64'(exp_q.size()), 64'd0);

        // Short tail chunk, chunk==0, and address wrap
        h0 = nhs;
        start_job(64'h8000, 32'h900, 32'h400);
        wait_done("job2_done");
        chk("job2_cmds", 64'(nhs - h0), 64'd3);
        h0 = nhs;
        start_job(64'h9000, 32'h900, 32'h0);
        wait_done("job3_done");
        chk("job3_cmds", 64'(nhs - h0), 64'd1);
        h0 = nhs;
        start_job(64'hFFFF_FFFF_FFFF_FF00, 32'h200, 32'h100);
        wait_done("job_wrap_done");
        chk("job_wrap_cmds", 64'(nhs - h0), 64'd2);
        chk("sb_empty_2", 64'(exp_q.size()), 64'd0);

        // Outstanding limit of 2 with completions withheld; handshake+completion in one cycle
        auto_done = 1'b0;
        h0 = nhs;
        start_job(64'h2000, 32'h400, 32'h100);
        ticks(12);
        chk("limit_two_cmds", 64'(nhs - h0), 64'd2);
        chk("limit_valid_low", 64'(bus.rd_valid), 64'd0);
        bus.rd_done = 1'b1;
        tick();
        chk("resume_valid", 64'(bus.rd_valid), 64'd1);
        chk("resume_paddr", bus.rd_paddr, 64'h2200);
        bus.rd_done = 1'b1;
        tick();
        chk("hs_done_valid", 64'(bus.rd_valid), 64'd1);
        chk("hs_done_paddr", bus.rd_paddr, 64'h2300);
        ticks(3);
        chk("drain_no_done", 64'(bus.job_done), 64'd0);
        bus.rd_done = 1'b1;
        tick();
        tick();
        chk("drain_one_left", 64'(bus.job_done), 64'd0);
        bus.rd_done = 1'b1;
        tick();
        chk("drain_job_done", 64'(bus.job_done), 64'd1);
        tick();
        chk("drain_done_pulse_end", 64'(bus.job_done), 64'd0);
        chk("drain_ready", 64'(bus.job_ready), 64'd1);
        chk("limit_job_cmds", 64'(nhs - h0), 64'd4);

        // Backpressure: command held stable for 10 cycles
        auto_done    = 1'b1;
        bus.rd_ready = 1'b0;
        h0 = nhs;
        start_job(64'h3000, 32'h200, 32'h100);
        for (int i = 0; i < 10 && !bus.rd_valid; i++) tick();
        for (int i = 0; i < 10; i++) begin
            chk("stall_valid", 64'(bus.rd_valid), 64'd1);
            chk("stall_paddr", bus.rd_paddr, 64'h3000);
            chk("stall_len", 64'(bus.rd_len), 64'h100);
            tick();
        end
        bus.rd_ready = 1'b1;
        wait_done("stall_job_done");
        chk("stall_cmds", 64'(nhs - h0), 64'd2);

        // Zero-length job and spurious completion
        h0 = nhs;
        start_job(64'h7000, 32'h0, 32'h100);
        chk("zero_job_done", 64'(bus.job_done), 64'd1);
        chk("zero_no_valid", 64'(bus.rd_valid), 64'd0);
        tick();
        chk("zero_done_end", 64'(bus.job_done), 64'd0);
        chk("zero_ready", 64'(bus.job_ready), 64'd1);
        chk("zero_cmds", 64'(nhs - h0), 64'd0);
        chk("err_clear_before", 64'(bus.err_spurious), 64'd0);
        bus.rd_done = 1'b1;
        tick();
        chk("err_set", 64'(bus.err_spurious), 64'd1);
        ticks(5);
        chk("err_sticky", 64'(bus.err_spurious), 64'd1);
        areset = 1'b1;
        tick();
        areset = 1'b0;
        chk("err_cleared_by_rst", 64'(bus.err_spurious), 64'd0);

        // Reset mid-job after 2 of 4 commands
        h0 = nhs;
        start_job(64'h1000, 32'h1000, 32'h400);
        for (int i = 0; i < 50 && (nhs - h0) < 2; i++) tick();
        chk("midrst_two_cmds", 64'(nhs - h0), 64'd2);
        areset = 1'b1;
        tick();
        exp_q.delete();
        chk("midrst_rd_valid", 64'(bus.rd_valid), 64'd0);
        chk("midrst_busy", 64'(bus.busy), 64'd0);
        chk("midrst_job_done", 64'(bus.job_done), 64'd0);
        chk("midrst_err", 64'(bus.err_spurious), 64'd0);
        chk("midrst_paddr", bus.rd_paddr, 64'd0);
        chk("midrst_len", 64'(bus.rd_len), 64'd0);
        areset = 1'b0;
        chk("midrst_ready", 64'(bus.job_ready), 64'd1);
        h0 = nhs;
        ticks(8);
        chk("midrst_no_cmds", 64'(nhs - h0), 64'd0);
        chk("midrst_late_done_err", 64'(bus.err_spurious), 64'd1);
        areset = 1'b1;
        tick();
        areset = 1'b0;
        h0 = nhs;
        start_job(64'h5000, 32'h800, 32'h400);
        wait_done("postrst_job_done");
        chk("postrst_cmds", 64'(nhs - h0), 64'd2);
        chk("postrst_err", 64'(bus.err_spurious), 64'd0);
        chk("final_sb_empty", 64'(exp_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
